// File: rtl/marker_decoder.sv
// Marker/command word decoder for a 16-bit K-coded link.
// It decodes single and multi-word markers into one-cycle pulses and keeps good-marker and error statistics.
`timescale 1ns/1ps
module marker_decoder #(
  parameter int WAIT_TIMEOUT = 16
) (
  input  logic        HCLK,
  input  logic        HRESETN,
  input  logic [15:0] RX_DATA,
  input  logic [1:0]  RX_KCHAR,
  input  logic        RX_VALID,
  input  logic        CNT_CLR,
  output logic        CLK_MARKER,
  output logic        EVT_MARKER,
  output logic        LOOPBACK,
  output logic        DIAG,
  output logic        DCS_TIMEOUT,
  output logic        RETRANS,
  output logic        DCS_REQ,
  output logic        UNUSED_CMD,
  output logic [3:0]  RETRANS_SEQ,
  output logic [31:0] MARKER_CNT,
  output logic [15:0] ERR_CNT,
  output logic [2:0]  ERR_CODE,
  output logic        ERR_PULSE
);

  localparam int TMO_W = (WAIT_TIMEOUT > 1) ? $clog2(WAIT_TIMEOUT) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(WAIT_TIMEOUT - 1);

  localparam logic [2:0] ERR_SEQ      = 3'd1;
  localparam logic [2:0] ERR_RET_DATA = 3'd2;
  localparam logic [2:0] ERR_ORPHAN   = 3'd3;
  localparam logic [2:0] ERR_ILLEGAL  = 3'd4;
  localparam logic [2:0] ERR_TIMEOUT  = 3'd5;
  localparam logic [2:0] ERR_KCHAR    = 3'd6;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CLK_WAIT = 3'd1,
    EVT_WAIT = 3'd2,
    RET_KN   = 3'd3,
    RET_SEQ  = 3'd4
  } state_t;

  // Pulse vector order: clk, evt, loopback, diag, dcs_timeout, retrans, dcs_req, unused_cmd
  state_t           state_r, state_nxt_s;
  logic [TMO_W-1:0] tmo_r, tmo_nxt_s;
  logic [7:0]       pulse_r, pulse_nxt_s;
  logic             err_s;
  logic [2:0]       err_code_s;
  logic             mark_inc_s;
  logic             seq_ld_s;

  function automatic logic is_bad_k(input logic [1:0] k, input logic [15:0] d);
    return (k == 2'b01) || ((k == 2'b11) && (d != 16'hBC3C));
  endfunction

  function automatic logic nibbles_equal(input logic [15:0] d);
    return (d[15:12] == d[11:8]) && (d[11:8] == d[7:4]) && (d[7:4] == d[3:0]);
  endfunction

  // Next-state, decode-event and timeout computation for the current word.
  always_comb begin
    state_nxt_s = state_r;
    tmo_nxt_s   = tmo_r;
    pulse_nxt_s = 8'h00;
    err_s       = 1'b0;
    err_code_s  = 3'd0;
    mark_inc_s  = 1'b0;
    seq_ld_s    = 1'b0;
    if (RX_VALID) begin
      tmo_nxt_s = '0;
      if (is_bad_k(RX_KCHAR, RX_DATA)) begin
        err_s       = 1'b1;
        err_code_s  = ERR_KCHAR;
        state_nxt_s = IDLE;
      end else begin
        case (state_r)
          IDLE: begin
            if (RX_KCHAR == 2'b10) begin
              if (RX_DATA[15:8] != 8'h1C) begin
                err_s      = 1'b1;
                err_code_s = ERR_ILLEGAL;
              end else begin
                case (RX_DATA[7:0])
                  8'h11: state_nxt_s = CLK_WAIT;
                  8'h10: state_nxt_s = EVT_WAIT;
                  8'h15: state_nxt_s = RET_KN;
                  8'h12: begin pulse_nxt_s[2] = 1'b1; mark_inc_s = 1'b1; end
                  8'h13: begin pulse_nxt_s[3] = 1'b1; mark_inc_s = 1'b1; end
                  8'h14: begin pulse_nxt_s[4] = 1'b1; mark_inc_s = 1'b1; end
                  8'h00: pulse_nxt_s[6] = 1'b1;
                  8'hEE, 8'hEF, 8'hEA, 8'hED: begin
                    err_s      = 1'b1;
                    err_code_s = ERR_ORPHAN;
                  end
                  default: pulse_nxt_s[7] = 1'b1;
                endcase
              end
            end else begin
              state_nxt_s = IDLE;
            end
          end
          CLK_WAIT: begin
            state_nxt_s = IDLE;
            if ((RX_KCHAR == 2'b10) && (RX_DATA == 16'h1CEE)) begin
              pulse_nxt_s[0] = 1'b1;
              mark_inc_s     = 1'b1;
            end else begin
              err_s      = 1'b1;
              err_code_s = ERR_SEQ;
            end
          end
          EVT_WAIT: begin
            state_nxt_s = IDLE;
            if ((RX_KCHAR == 2'b10) && (RX_DATA == 16'h1CEF)) begin
              pulse_nxt_s[1] = 1'b1;
              mark_inc_s     = 1'b1;
            end else begin
              err_s      = 1'b1;
              err_code_s = ERR_SEQ;
            end
          end
          RET_KN: begin
            if ((RX_KCHAR == 2'b10) && (RX_DATA == 16'h1CEA)) begin
              state_nxt_s = RET_SEQ;
            end else begin
              state_nxt_s = IDLE;
              err_s       = 1'b1;
              err_code_s  = ERR_SEQ;
            end
          end
          RET_SEQ: begin
            state_nxt_s = IDLE;
            if ((RX_KCHAR == 2'b00) && nibbles_equal(RX_DATA)) begin
              pulse_nxt_s[5] = 1'b1;
              mark_inc_s     = 1'b1;
              seq_ld_s       = 1'b1;
            end else begin
              err_s      = 1'b1;
              err_code_s = ERR_RET_DATA;
            end
          end
          default: state_nxt_s = IDLE;
        endcase
      end
    end else if (state_r != IDLE) begin
      if (tmo_r == TMO_LAST) begin
        err_s       = 1'b1;
        err_code_s  = ERR_TIMEOUT;
        state_nxt_s = IDLE;
        tmo_nxt_s   = '0;
      end else begin
        tmo_nxt_s = tmo_r + TMO_W'(1);
      end
    end else begin
      tmo_nxt_s = '0;
    end
  end

  // State, pulse and statistics registers; CNT_CLR overrides any same-cycle update.
  always_ff @(posedge HCLK or negedge HRESETN) begin
    if (!HRESETN) begin
      state_r     <= IDLE;
      tmo_r       <= '0;
      pulse_r     <= 8'h00;
      ERR_PULSE   <= 1'b0;
      RETRANS_SEQ <= 4'd0;
      MARKER_CNT  <= 32'd0;
      ERR_CNT     <= 16'd0;
      ERR_CODE    <= 3'd0;
    end else begin
      state_r   <= state_nxt_s;
      tmo_r     <= tmo_nxt_s;
      pulse_r   <= pulse_nxt_s;
      ERR_PULSE <= err_s;
      if (seq_ld_s) begin
        RETRANS_SEQ <= RX_DATA[3:0];
      end
      if (CNT_CLR) begin
        MARKER_CNT <= 32'd0;
        ERR_CNT    <= 16'd0;
        ERR_CODE   <= 3'd0;
      end else begin
        if (mark_inc_s) begin
          MARKER_CNT <= MARKER_CNT + 32'd1;
        end
        if (err_s) begin
          ERR_CODE <= err_code_s;
          if (ERR_CNT != 16'hFFFF) begin
            ERR_CNT <= ERR_CNT + 16'd1;
          end
        end
      end
    end
  end

  assign CLK_MARKER  = pulse_r[0];
  assign EVT_MARKER  = pulse_r[1];
  assign LOOPBACK    = pulse_r[2];
  assign DIAG        = pulse_r[3];
  assign DCS_TIMEOUT = pulse_r[4];
  assign RETRANS     = pulse_r[5];
  assign DCS_REQ     = pulse_r[6];
  assign UNUSED_CMD  = pulse_r[7];

endmodule

// File: tb/tb_marker_decoder.sv
// Scoreboard bench for marker_decoder: directed words push expected output events, a monitor pops and compares.
`timescale 1ns/1ps
module tb_marker_decoder;

  logic        HCLK = 1'b0;
  logic        HRESETN = 1'b0;
  logic [15:0] RX_DATA = 16'h0000;
  logic [1:0]  RX_KCHAR = 2'b00;
  logic        RX_VALID = 1'b0;
  logic        CNT_CLR = 1'b0;
  logic        CLK_MARKER, EVT_MARKER, LOOPBACK, DIAG, DCS_TIMEOUT, RETRANS, DCS_REQ, UNUSED_CMD;
  logic [3:0]  RETRANS_SEQ;
  logic [31:0] MARKER_CNT;
  logic [15:0] ERR_CNT;
  logic [2:0]  ERR_CODE;
  logic        ERR_PULSE;

  marker_decoder #(.WAIT_TIMEOUT(16)) dut (
    .HCLK(HCLK), .HRESETN(HRESETN), .RX_DATA(RX_DATA), .RX_KCHAR(RX_KCHAR),
    .RX_VALID(RX_VALID), .CNT_CLR(CNT_CLR), .CLK_MARKER(CLK_MARKER),
    .EVT_MARKER(EVT_MARKER), .LOOPBACK(LOOPBACK), .DIAG(DIAG),
    .DCS_TIMEOUT(DCS_TIMEOUT), .RETRANS(RETRANS), .DCS_REQ(DCS_REQ),
    .UNUSED_CMD(UNUSED_CMD), .RETRANS_SEQ(RETRANS_SEQ), .MARKER_CNT(MARKER_CNT),
    .ERR_CNT(ERR_CNT), .ERR_CODE(ERR_CODE), .ERR_PULSE(ERR_PULSE)
  );

  always #5 HCLK = ~HCLK;

  localparam int B_CLK = 0, B_EVT = 1, B_LOOP = 2, B_DIAG = 3, B_DTO = 4,
                 B_RET = 5, B_DREQ = 6, B_UNU = 7, B_ERR = 8;

  typedef struct {
    logic [8:0]  pulses;
    logic [3:0]  seq;
    logic [31:0] mcnt;
    logic [15:0] ecnt;
    logic [2:0]  ecode;
    int          due;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  logic [31:0] m_cnt = 32'd0;
  logic [15:0] e_cnt = 16'd0;
  logic [2:0]  e_code = 3'd0;
  logic [3:0]  m_seq = 4'd0;

  initial begin
    forever begin
      @(posedge HCLK);
      cyc++;
    end
  end

  // Monitor: every cycle with any output pulse consumes one expected event.
  initial begin
    logic [8:0] act;
    exp_t e;
    forever begin
      @(negedge HCLK);
      act = {ERR_PULSE, UNUSED_CMD, DCS_REQ, RETRANS, DCS_TIMEOUT, DIAG, LOOPBACK, EVT_MARKER, CLK_MARKER};
      if (HRESETN && act != 9'd0) begin
        checks++;
        if (q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_event act_pulses=%h cyc=%0d", act, cyc);
        end else begin
          e = q.pop_front();
          if (act != e.pulses || RETRANS_SEQ != e.seq || MARKER_CNT != e.mcnt ||
              ERR_CNT != e.ecnt || ERR_CODE != e.ecode || cyc != e.due) begin
            failures++;
            $display("FAIL event got pulses=%h seq=%h mcnt=%0d ecnt=%h code=%0d cyc=%0d want pulses=%h seq=%h mcnt=%0d ecnt=%h code=%0d cyc=%0d",
                     act, RETRANS_SEQ, MARKER_CNT, ERR_CNT, ERR_CODE, cyc,
                     e.pulses, e.seq, e.mcnt, e.ecnt, e.ecode, e.due);
          end
        end
      end
    end
  end

  task automatic send(input logic [15:0] d, input logic [1:0] k, input logic clr = 1'b0);
    @(posedge HCLK);
    #1;
    RX_DATA  = d;
    RX_KCHAR = k;
    RX_VALID = 1'b1;
    CNT_CLR  = clr;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge HCLK);
      #1;
      RX_VALID = 1'b0;
      RX_DATA  = 16'h0000;
      RX_KCHAR = 2'b00;
      CNT_CLR  = 1'b0;
    end
  endtask

  // Record one expected output event and advance the reference counters.
  task automatic expect_ev(input int bitn, input logic [2:0] code = 3'd0,
                           input logic [3:0] sq = 4'd0, input logic clr = 1'b0,
                           input int lat = 1);
    exp_t e;
    e.pulses = 9'd0;
    e.pulses[bitn] = 1'b1;
    if (bitn <= B_RET) m_cnt = m_cnt + 32'd1;
    if (bitn == B_RET) m_seq = sq;
    if (bitn == B_ERR) begin
      e_code = code;
      if (e_cnt != 16'hFFFF) e_cnt = e_cnt + 16'd1;
    end
    if (clr) begin
      m_cnt  = 32'd0;
      e_cnt  = 16'd0;
      e_code = 3'd0;
    end
    e.seq   = m_seq;
    e.mcnt  = m_cnt;
    e.ecnt  = e_cnt;
    e.ecode = e_code;
    e.due   = cyc + lat;
    q.push_back(e);
  endtask

  task automatic drain();
    int n;
    n = 0;
    idle(1);
    while (q.size() != 0 && n < 50) begin
      @(posedge HCLK);
      n++;
    end
    repeat (3) @(posedge HCLK);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d required=0", q.size());
    end
  endtask

  task automatic check_zero(input string name);
    @(negedge HCLK);
    checks++;
    if ({CLK_MARKER, EVT_MARKER, LOOPBACK, DIAG, DCS_TIMEOUT, RETRANS, DCS_REQ, UNUSED_CMD,
         ERR_PULSE, RETRANS_SEQ, MARKER_CNT, ERR_CNT, ERR_CODE} != 65'd0) begin
      failures++;
      $display("FAIL %s mcnt=%0d ecnt=%h code=%0d seq=%h required all zero",
               name, MARKER_CNT, ERR_CNT, ERR_CODE, RETRANS_SEQ);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(posedge HCLK);
    #1 HRESETN = 1'b1;
    check_zero("reset_state");

    send(16'h1C11, 2'b10); send(16'h1CEE, 2'b10); expect_ev(B_CLK);
    send(16'h1C10, 2'b10); send(16'h1CEF, 2'b10); expect_ev(B_EVT);
    send(16'h1C15, 2'b10); send(16'h1CEA, 2'b10);
    send(16'h7777, 2'b00); expect_ev(B_RET, 3'd0, 4'h7);
    send(16'h1C15, 2'b10); send(16'h1CEA, 2'b10);
    send(16'h7077, 2'b00); expect_ev(B_ERR, 3'd2);
    send(16'h1C10, 2'b10); send(16'h1C10, 2'b10); expect_ev(B_ERR, 3'd1);
    send(16'h1C12, 2'b10); expect_ev(B_LOOP);
    send(16'h1C13, 2'b10); expect_ev(B_DIAG);
    send(16'h1C14, 2'b10); expect_ev(B_DTO);
    send(16'h1C00, 2'b10); expect_ev(B_DREQ);
    send(16'h1C20, 2'b10); expect_ev(B_UNU);
    send(16'h1234, 2'b10); expect_ev(B_ERR, 3'd4);
    send(16'h1CEE, 2'b10); expect_ev(B_ERR, 3'd3);
    send(16'h1CEF, 2'b10); expect_ev(B_ERR, 3'd3);
    send(16'h1CEA, 2'b10); expect_ev(B_ERR, 3'd3);
    send(16'h1CED, 2'b10); expect_ev(B_ERR, 3'd3);
    send(16'hBC3C, 2'b11); send(16'h5555, 2'b00);
    send(16'h1234, 2'b11); expect_ev(B_ERR, 3'd6);
    send(16'h1C11, 2'b10); send(16'h0000, 2'b01); expect_ev(B_ERR, 3'd6);
    send(16'h1CEE, 2'b10); expect_ev(B_ERR, 3'd3);
    send(16'h1C15, 2'b10); send(16'h1C11, 2'b10); expect_ev(B_ERR, 3'd1);
    send(16'h1CEE, 2'b10); expect_ev(B_ERR, 3'd3);

    send(16'h1C11, 2'b10); expect_ev(B_ERR, 3'd5, 4'd0, 1'b0, 17);
    idle(16);
    send(16'h1C12, 2'b10); expect_ev(B_LOOP);
    send(16'h1C11, 2'b10); idle(15);
    send(16'h1CEE, 2'b10); expect_ev(B_CLK);
    send(16'h1C15, 2'b10); idle(15); send(16'h1CEA, 2'b10); idle(15);
    send(16'hAAAA, 2'b00); expect_ev(B_RET, 3'd0, 4'hA);
    drain();

    send(16'h1C11, 2'b10);
    @(posedge HCLK);
    #1;
    HRESETN = 1'b0;
    RX_VALID = 1'b0;
    m_cnt = 32'd0; e_cnt = 16'd0; e_code = 3'd0; m_seq = 4'd0;
    @(posedge HCLK);
    #1 HRESETN = 1'b1;
    check_zero("reset_mid_marker");
    send(16'h1CEE, 2'b10); expect_ev(B_ERR, 3'd3);

    send(16'h1C10, 2'b10); send(16'h1CEF, 2'b10, 1'b1); expect_ev(B_EVT, 3'd0, 4'd0, 1'b1);
    send(16'h1C12, 2'b10); expect_ev(B_LOOP);

    while (e_cnt != 16'hFFFF) begin
      send(16'h1234, 2'b10); expect_ev(B_ERR, 3'd4);
    end
    send(16'h1C10, 2'b10); send(16'h1C11, 2'b10); expect_ev(B_ERR, 3'd1);
    send(16'h1234, 2'b10, 1'b1); expect_ev(B_ERR, 3'd4, 4'd0, 1'b1);
    send(16'h1C13, 2'b10); expect_ev(B_DIAG);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/marker_decoder.md
MARKER_DECODER -- requirements
Module: marker_decoder

Interface
REQ-001 Parameter: WAIT_TIMEOUT, default 16, maximum HCLK cycles without RX_VALID allowed while a multi-word marker is in progress.
REQ-002 HCLK  input  1  block clock.
REQ-003 HRESETN  input  1  reset, asynchronous, active-low.
REQ-004 RX_DATA  input  16  received word; command words have [15:8]=0x1C.
REQ-005 RX_KCHAR  input  2  K flags: 11 comma, 10 command, 00 data word.
REQ-006 RX_VALID  input  1  RX_DATA/RX_KCHAR valid this cycle.
REQ-007 CNT_CLR  input  1  synchronous clear of MARKER_CNT, ERR_CNT and ERR_CODE.
REQ-008 CLK_MARKER, EVT_MARKER, LOOPBACK, DIAG, DCS_TIMEOUT, RETRANS, DCS_REQ, UNUSED_CMD  output  1 each  single-cycle decode pulses.
REQ-009 RETRANS_SEQ  output  4  sequence number of the last good retransmit request.
REQ-010 MARKER_CNT  output  32  count of good markers.
REQ-011 ERR_CNT  output  16  count of protocol errors.
REQ-012 ERR_CODE  output  3  code of the most recent error.
REQ-013 ERR_PULSE  output  1  single-cycle pulse per error.

Function
REQ-014 All outputs SHALL be registered; a pulse SHALL assert the cycle after the valid word that completes its marker.
REQ-015 Cycles with RX_VALID=0 SHALL leave the FSM state unchanged except for the timeout counter.
REQ-016 FSM states SHALL be IDLE, CLK_WAIT, EVT_WAIT, RET_KN, RET_SEQ.
REQ-017 In IDLE, comma (11, 0xBC3C) and data words (00) SHALL be ignored.
REQ-018 IDLE command-word decode (KCHAR=10), first match wins:
- 0x1C11 SHALL go to CLK_WAIT.
- 0x1C10 SHALL go to EVT_WAIT.
- 0x1C15 SHALL go to RET_KN.
- 0x1C12 SHALL pulse LOOPBACK.
- 0x1C13 SHALL pulse DIAG.
- 0x1C14 SHALL pulse DCS_TIMEOUT.
- 0x1C00 SHALL pulse DCS_REQ.
- 0x1CEE, 0x1CEF, 0x1CEA, 0x1CED SHALL raise error 3 (orphan complement).
- Any other 0x1Cxx SHALL pulse UNUSED_CMD.
- [15:8]≠0x1C SHALL raise error 4 (illegal command).
REQ-019 KCHAR=01, or KCHAR=11 with data≠0xBC3C, SHALL raise error 6 in any state and return to IDLE.
REQ-020 CLK_WAIT: the next valid word 0x1CEE/10 SHALL pulse CLK_MARKER; any other word SHALL raise error 1. Both cases SHALL return to IDLE.
REQ-021 EVT_WAIT: the next valid word 0x1CEF/10 SHALL pulse EVT_MARKER; any other word SHALL raise error 1. Both cases SHALL return to IDLE.
REQ-022 RET_KN: 0x1CEA/10 SHALL go to RET_SEQ; any other word SHALL raise error 1 and return to IDLE.
REQ-023 RET_SEQ: a KCHAR=00 word with all four nibbles equal SHALL pulse RETRANS and load RETRANS_SEQ with the nibble value; any other word SHALL raise error 2. Both cases SHALL return to IDLE.
REQ-024 A word that terminates a wait state with an error SHALL be discarded, not re-decoded in IDLE.
REQ-025 Timeout: in any wait state, WAIT_TIMEOUT consecutive cycles with RX_VALID=0 SHALL raise error 5 and return to IDLE; the timeout counter SHALL reset on every valid word and on entry to IDLE.
REQ-026 Each error SHALL pulse ERR_PULSE, load ERR_CODE, and increment ERR_CNT, saturating at 0xFFFF.
REQ-027 MARKER_CNT SHALL increment by 1 on CLK_MARKER, EVT_MARKER, LOOPBACK, DIAG, DCS_TIMEOUT and RETRANS (not on DCS_REQ or UNUSED_CMD), and SHALL wrap at 2^32.
REQ-028 CNT_CLR coincident with an increment or error SHALL win: counters 0 and ERR_CODE 0; the decode pulses SHALL still fire.

Reset
REQ-029 HRESETN low SHALL force IDLE and clear the timeout counter, all pulses, RETRANS_SEQ, MARKER_CNT, ERR_CNT and ERR_CODE to 0, including mid-marker.

Verification
REQ-030 Valid stream 0x1C11/10, 0x1CEE/10 -> CLK_MARKER pulse one cycle later, MARKER_CNT=1, ERR_CNT=0.
REQ-031 0x1C15/10, 0x1CEA/10, 0x7777/00 -> RETRANS pulse, RETRANS_SEQ=7; with third word 0x7077/00 -> ERR_CODE=2, no RETRANS.
REQ-032 0x1C10/10, 0x1C10/10 -> ERR_CODE=1, ERR_CNT=1, no EVT_MARKER, FSM in IDLE.
REQ-033 0x1C11/10 then RX_VALID=0 for 16 cycles -> ERR_CODE=5 on the 16th idle cycle; 15 idle cycles then 0x1CEE -> CLK_MARKER pulse.
REQ-034 0x1234/10 -> ERR_CODE=4; 0x1C20/10 -> UNUSED_CMD pulse, MARKER_CNT unchanged; 0x1CEE/10 in IDLE -> ERR_CODE=3.
REQ-035 ERR_CNT preloaded to 0xFFFF by errors, then one more error -> ERR_CNT stays 0xFFFF; CNT_CLR on the same cycle as a marker completes -> MARKER_CNT=0.
